// File: rtl/pop_arbiter_if.sv
// Bundle of FIFO-side and downstream-side signals of the five-way pop arbiter.
// The arbiter takes the slave view; the FIFO/environment side takes the master view.
interface pop_arbiter_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  empty_0;
    logic                  empty_1;
    logic                  empty_2;
    logic                  empty_3;
    logic                  empty_4;
    logic [DATA_WIDTH-1:0] data_in_0;
    logic [DATA_WIDTH-1:0] data_in_1;
    logic [DATA_WIDTH-1:0] data_in_2;
    logic [DATA_WIDTH-1:0] data_in_3;
    logic [DATA_WIDTH-1:0] data_in_4;
    logic                  out_almost_full;
    logic                  pop_0;
    logic                  pop_1;
    logic                  pop_2;
    logic                  pop_3;
    logic                  pop_4;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  idle;

    modport master (
        output empty_0, empty_1, empty_2, empty_3, empty_4,
        output data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
        output out_almost_full,
        input  pop_0, pop_1, pop_2, pop_3, pop_4,
        input  push, data_out, idle
    );

    modport slave (
        input  empty_0, empty_1, empty_2, empty_3, empty_4,
        input  data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
        input  out_almost_full,
        output pop_0, pop_1, pop_2, pop_3, pop_4,
        output push, data_out, idle
    );
endinterface

// File: rtl/pop_arbiter.sv
// Round-robin drain of five registered-read FIFOs into one downstream FIFO,
// with combinational one-hot pops and a fixed two-cycle pop-to-push latency.
module pop_arbiter #(
    parameter int DATA_WIDTH = 6
) (
    input  logic            clk,
    input  logic            reset,
    pop_arbiter_if.slave    bus
);
    localparam int NUM_FIFOS = 5;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              rr_ptr_q, rr_ptr_d;
    logic                    v1_q, v1_d;
    logic [2:0]              sel1_q, sel1_d;
    logic                    push_q, push_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    idle_q, idle_d;

    logic [NUM_FIFOS-1:0]    empty_s;
    logic [NUM_FIFOS-1:0]    pop_s;
    logic [2:0]              ptr_s;
    logic [2:0]              search_idx_s;
    logic [2:0]              grant_s;
    logic                    grant_vld_s;
    logic                    eligible_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;

    // Successor modulo five; out-of-range indices fold to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        logic [2:0] r;
        case (idx)
            3'd0:    r = 3'd1;
            3'd1:    r = 3'd2;
            3'd2:    r = 3'd3;
            3'd3:    r = 3'd4;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    assign empty_s = {bus.empty_4, bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};

    // First non-empty FIFO at or after the pointer, wrapping.
    always_comb begin
        ptr_s        = (rr_ptr_q > 3'd4) ? 3'd0 : rr_ptr_q;
        search_idx_s = ptr_s;
        grant_s      = 3'd0;
        grant_vld_s  = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (!grant_vld_s && !empty_s[search_idx_s]) begin
                grant_vld_s = 1'b1;
                grant_s     = search_idx_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
            search_idx_s = next_idx(search_idx_s);
        end
    end

    assign eligible_s = !reset && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE))
                        && !bus.out_almost_full && grant_vld_s;
    assign pop_s      = eligible_s ? (5'b00001 << grant_s) : 5'b00000;

    // Stage-2 read mux over the FIFO selected in stage 1.
    always_comb begin
        case (sel1_q)
            3'd0:    sel_data_s = bus.data_in_0;
            3'd1:    sel_data_s = bus.data_in_1;
            3'd2:    sel_data_s = bus.data_in_2;
            3'd3:    sel_data_s = bus.data_in_3;
            3'd4:    sel_data_s = bus.data_in_4;
            default: sel_data_s = bus.data_in_0;
        endcase
    end

    // Next-state: FSM, pointer, pipeline and idle flag.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = eligible_s ? next_idx(grant_s) : ptr_s;
        v1_d       = eligible_s;
        sel1_d     = eligible_s ? grant_s : 3'd0;
        push_d     = v1_q;
        data_out_d = v1_q ? sel_data_s : data_out_q;
        idle_d     = (&empty_s) && !v1_q;
        case (state_q)
            ST_RESET:  state_d = ST_IDLE;
            ST_IDLE: begin
                if (!(&empty_s) && !bus.out_almost_full) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!eligible_s && !v1_q && !push_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // State and pipeline registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            rr_ptr_q   <= 3'd0;
            v1_q       <= 1'b0;
            sel1_q     <= 3'd0;
            push_q     <= 1'b0;
            data_out_q <= {DATA_WIDTH{1'b0}};
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            v1_q       <= v1_d;
            sel1_q     <= sel1_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
            idle_q     <= idle_d;
        end
    end

    assign bus.pop_0    = pop_s[0];
    assign bus.pop_1    = pop_s[1];
    assign bus.pop_2    = pop_s[2];
    assign bus.pop_3    = pop_s[3];
    assign bus.pop_4    = pop_s[4];
    assign bus.push     = push_q;
    assign bus.data_out = data_out_q;
    assign bus.idle     = idle_q;
endmodule

// File: tb/tb_pop_arbiter.sv
// Directed bench for pop_arbiter: reset, rotation with wrap, skipping empties,
// backpressure, reset mid-flight and pop/push accounting against a FIFO-level model.
module tb_pop_arbiter;
    logic clk;
    logic reset;
    pop_arbiter_if #(.DATA_WIDTH(6)) bus ();

    pop_arbiter #(.DATA_WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         bad;
    int         lvl [5];
    int         pop_cnt [5];
    int         push_cnt;
    logic       rst_v;
    logic       af_v;
    logic [4:0] pops;

    logic [4:0] sk_pop [4];
    logic [5:0] sk_dat [4];
    logic       bp_af  [9];
    logic [4:0] bp_pop [9];
    logic       bp_psh [9];
    logic [5:0] bp_dat [9];
    logic [4:0] cn_pop [8];
    logic       cn_psh [8];
    logic [5:0] cn_dat [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle, sample, then retire popped words from the FIFO levels.
    task automatic cycle();
        @(negedge clk);
        reset               = rst_v;
        bus.out_almost_full = af_v;
        bus.empty_0 = (lvl[0] == 0);
        bus.empty_1 = (lvl[1] == 0);
        bus.empty_2 = (lvl[2] == 0);
        bus.empty_3 = (lvl[3] == 0);
        bus.empty_4 = (lvl[4] == 0);
        #1;
        pops = {bus.pop_4, bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0};
        for (int k = 0; k < 5; k++) begin
            if (pops[k]) begin
                pop_cnt[k]++;
                if (lvl[k] > 0) lvl[k]--;
            end
        end
        if (bus.push === 1'b1) push_cnt++;
    endtask

    initial begin
        total = 0; bad = 0; push_cnt = 0;
        rst_v = 1'b1; af_v = 1'b0;
        reset = 1'b1;
        bus.out_almost_full = 1'b0;
        bus.data_in_0 = 6'd10; bus.data_in_1 = 6'd11; bus.data_in_2 = 6'd12;
        bus.data_in_3 = 6'd13; bus.data_in_4 = 6'd14;
        for (int k = 0; k < 5; k++) begin lvl[k] = 100; pop_cnt[k] = 0; end
        bus.empty_0 = 1'b0; bus.empty_1 = 1'b0; bus.empty_2 = 1'b0;
        bus.empty_3 = 1'b0; bus.empty_4 = 1'b0;

        sk_pop = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};
        sk_dat = '{6'd14, 6'd10, 6'd11, 6'd13};
        bp_af  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bp_pop = '{5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b00000,
                   5'b00000, 5'b00000, 5'b01000, 5'b10000};
        bp_psh = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bp_dat = '{6'd11, 6'd13, 6'd14, 6'd10, 6'd11, 6'd12, 6'd12, 6'd12, 6'd12};
        cn_pop = '{5'b00001, 5'b00100, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        cn_psh = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cn_dat = '{6'd0, 6'd0, 6'd10, 6'd12, 6'd10, 6'd10, 6'd10, 6'd10};

        // Reset held two cycles with every FIFO non-empty
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_pop",  pops, 5'b00000);
            chk("rst_push", bus.push, 1'b0);
            chk("rst_data", bus.data_out, 6'd0);
            chk("rst_idle", bus.idle, 1'b1);
        end
        rst_v = 1'b0;
        cycle();
        chk("first_cycle_pop", pops, 5'b00000);

        // Rotation 0,1,2,3,4,0 with data two cycles later
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_pop", pops, 5'b00001 << (i % 5));
            if (i >= 2) begin
                chk("rr_push", bus.push, 1'b1);
                chk("rr_data", bus.data_out, 6'(((i - 2) % 5) + 10));
            end
        end

        // Only FIFOs 1 and 3 non-empty
        lvl[0] = 0; lvl[2] = 0; lvl[4] = 0;
        for (int j = 0; j < 4; j++) begin
            cycle();
            chk("skip_pop",  pops, sk_pop[j]);
            chk("skip_push", bus.push, 1'b1);
            chk("skip_data", bus.data_out, sk_dat[j]);
        end

        // Almost-full raised the cycle after pop_2, dropped after three cycles
        for (int k = 0; k < 5; k++) lvl[k] = 100;
        for (int j = 0; j < 9; j++) begin
            af_v = bp_af[j];
            cycle();
            chk("bp_pop",  pops, bp_pop[j]);
            chk("bp_push", bus.push, bp_psh[j]);
            chk("bp_data", bus.data_out, bp_dat[j]);
        end
        chk("bp_idle", bus.idle, 1'b0);

        // Reset one cycle after pop_4: that word must never be pushed
        rst_v = 1'b1;
        cycle();
        chk("mid_rst_pop",  pops, 5'b00000);
        chk("mid_rst_push", bus.push, 1'b1);
        chk("mid_rst_data", bus.data_out, 6'd13);
        rst_v = 1'b0;
        cycle();
        chk("post_rst_pop",  pops, 5'b00000);
        chk("post_rst_push", bus.push, 1'b0);
        chk("post_rst_data", bus.data_out, 6'd0);
        chk("post_rst_idle", bus.idle, 1'b1);

        // FIFO 0 holds three words, FIFO 2 one word
        lvl[0] = 3; lvl[1] = 0; lvl[2] = 1; lvl[3] = 0; lvl[4] = 0;
        for (int k = 0; k < 5; k++) pop_cnt[k] = 0;
        push_cnt = 0;
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk("cnt_pop",  pops, cn_pop[j]);
            chk("cnt_push", bus.push, cn_psh[j]);
            chk("cnt_data", bus.data_out, cn_dat[j]);
            if (j >= 5) chk("cnt_idle", bus.idle, (j >= 6) ? 1'b1 : 1'b0);
        end
        chk("count_0", pop_cnt[0], 3);
        chk("count_2", pop_cnt[2], 1);
        chk("push_total", push_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pop_arbiter.md
# pop_arbiter

Round-robin scheduler that drains five input FIFOs into one downstream FIFO. It generates the one-hot `pop_0..pop_4` strobes consumed by the per-FIFO pop counters, and forwards the popped words with a fixed two-cycle latency. Downstream backpressure comes from an almost-full flag. The block sits between the five class FIFOs and the output FIFO, directly upstream of the counter bank.

## Interface

Parameters:
- `DATA_WIDTH`, default 6: word width of every FIFO.
- `NUM_FIFOS`, fixed 5: number of input FIFOs. Not overridable; ports are explicit.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `empty_0..empty_4`  in  1 each: empty flag of input FIFO k.
- `data_in_0..data_in_4`  in  DATA_WIDTH each: read data of FIFO k. Valid the cycle after `pop_k` (registered-read FIFOs).
- `out_almost_full`  in  1: downstream FIFO can accept at most 2 more words.
- `pop_0..pop_4`  out  1 each: combinational pop strobes. At most one high per cycle.
- `push`  out  1: registered write strobe to the downstream FIFO.
- `data_out`  out  DATA_WIDTH: registered word accompanying `push`.
- `idle`  out  1: registered; high when no word is in flight and all inputs are empty.

## Operation

- State machine, encoding free:
  - RESET → IDLE on the first edge with `reset`=0.
  - IDLE → ACTIVE when any `empty_k`=0 and `out_almost_full`=0.
  - ACTIVE → IDLE when no pop is issued this cycle and both pipeline stages are empty.
  - `reset`=1 forces RESET from any state at the next edge.
- Grant, combinational:
  - Eligible when state is IDLE or ACTIVE, `out_almost_full`=0, and some `empty_k`=0.
  - Grant = first non-empty k searching from `rr_ptr` upward, mod 5.
  - Assert `pop_k` for that k only.
  - No pop in RESET or while `reset`=1.
- `rr_ptr` (3 bits, range 0..4):
  - On a grant to k, update to (k+1) mod 5. Wrap: a grant to 4 gives 0.
  - Unchanged when there is no grant.
  - Values 5..7 are unreachable; if reached, treat as 0.
- Pipeline:
  - Stage 1 registers `{v1, sel1}` = {pop issued, granted k}.
  - Stage 2, at the next edge: `push` ← v1 and `data_out` ← `data_in_sel1`.
  - `data_out` holds its value when `push` is 0.
- Backpressure:
  - `out_almost_full` only blocks new pops.
  - Words already in stage 1 or 2 always complete; the 2-entry slack covers them.
- Simultaneous events:
  - A FIFO becoming non-empty in the same cycle the pointer passes it waits for the next rotation.
  - `empty_k` and `out_almost_full` are sampled in the same cycle as the pop they gate.

## Timing

- Reset values (after a `reset`=1 edge):
  - `rr_ptr`=0, `v1`=0, `sel1`=0.
  - `push`=0, `data_out`=0, `idle`=1.
  - State RESET.
  - `pop_*`=0 combinationally while `reset`=1.
- Latency: `pop_k` in cycle t → `push`=1 with the FIFO k word in cycle t+2.
- Throughput: one word per cycle when any input is non-empty and there is no backpressure.
- `idle` = registered (all empty & !v1 & !push-next). It goes low the cycle after the first pop and returns high one cycle after the last `push`.
- Reset mid-operation:
  - In-flight words are discarded; `push` is 0 the cycle after the reset edge.
  - Pointer returns to 0.

## Test plan

- Reset: hold `reset`=1 for 2 cycles with all FIFOs non-empty. Required: all `pop_*`=0, `push`=0, `data_out`=0, `idle`=1.
- Round-robin with wrap:
  - Stimulus: all five non-empty, `data_in_k`=k+10.
  - Required pops: `pop_0`,1,2,3,4,0 in consecutive cycles.
  - Required `data_out`: 10,11,12,13,14,10, starting 2 cycles after the first pop.
- Skip empties: only FIFOs 1 and 3 non-empty. Required: pops alternate 1,3,1,3; `rr_ptr` never stalls on an empty FIFO.
- Backpressure:
  - Stimulus: raise `out_almost_full` in the cycle after `pop_2`.
  - Required: no new pop while it is high; the 2 in-flight words are still pushed; popping resumes at FIFO 3 when it drops.
- Reset mid-flight: assert `reset` one cycle after `pop_4`. Required: no `push` for that word, `rr_ptr`=0; after release the first pop is to the lowest non-empty FIFO ≥0.
- Counter interaction: with the counter bank attached, pop FIFO 0 three times and FIFO 2 once. Required: count(idx=0)=3, count(idx=2)=1, and four `push` pulses in total.
